// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit.
// The master modport is driven by the ID/EX/LSU side and the slave modport by the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MAX_LD  = 4
) ();
    localparam int unsigned SW = $clog2(NUM_FWD + 1);
    localparam int unsigned CW = $clog2(MAX_LD + 1);

    logic [NUM_FWD-1:0]        fwd_wren_i;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd_i;
    logic [NUM_SRC*REG_AW-1:0] ex_rs_i;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_is_load_i;
    logic                      ex_is_load_i;
    logic [REG_AW-1:0]         ex_rd_i;
    logic                      ld_issue_i;
    logic [REG_AW-1:0]         ld_issue_rd_i;
    logic                      ld_ret_i;
    logic [REG_AW-1:0]         ld_ret_rd_i;
    logic [NUM_SRC*SW-1:0]     fwd_sel_o;
    logic                      stall_o;
    logic [CW-1:0]             ld_cnt_o;
    logic                      ret_err_o;
    logic [31:0]               stall_cnt_o;

    modport master (
        output fwd_wren_i, fwd_rd_i, ex_rs_i, id_rs_i, id_rd_i, id_is_load_i,
               ex_is_load_i, ex_rd_i, ld_issue_i, ld_issue_rd_i, ld_ret_i, ld_ret_rd_i,
        input  fwd_sel_o, stall_o, ld_cnt_o, ret_err_o, stall_cnt_o
    );

    modport slave (
        input  fwd_wren_i, fwd_rd_i, ex_rs_i, id_rs_i, id_rd_i, id_is_load_i,
               ex_is_load_i, ex_rd_i, ld_issue_i, ld_issue_rd_i, ld_ret_i, ld_ret_rd_i,
        output fwd_sel_o, stall_o, ld_cnt_o, ret_err_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX bypass select, pending-load scoreboard and ID stall for the RV32I core.
// Optional stall-cycle counter enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_unit #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MAX_LD  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fwd_hazard_unit_if.slave     hz
);
    localparam int unsigned SW   = $clog2(NUM_FWD + 1);
    localparam int unsigned CW   = $clog2(MAX_LD + 1);
    localparam int unsigned CW1  = CW + 1;
    localparam int unsigned NREG = 2 ** REG_AW;

    logic [NREG-1:0]       r_busy;
    logic [CW-1:0]         r_ld_cnt;
    logic                  r_ret_err;
    logic [NUM_SRC*SW-1:0] w_fwd_sel;
    logic                  w_set;
    logic                  w_ret_ok;
    logic                  w_load_use;
    logic                  w_pending;
    logic                  w_waw;
    logic                  w_cap;
    logic                  w_stall;

    // Walk oldest to youngest so the youngest matching stage overwrites the select.
    always_comb begin
        w_fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (hz.fwd_wren_i[k] &&
                    hz.fwd_rd_i[k*REG_AW +: REG_AW] != '0 &&
                    hz.fwd_rd_i[k*REG_AW +: REG_AW] == hz.ex_rs_i[s*REG_AW +: REG_AW])
                    w_fwd_sel[s*SW +: SW] = SW'(k + 1);
            end
        end
    end

    assign w_set    = hz.ld_issue_i && (hz.ld_issue_rd_i != '0);
    assign w_ret_ok = hz.ld_ret_i && r_busy[hz.ld_ret_rd_i];

    // A return landing this cycle supplies the data, so it lifts the pending stall early.
    always_comb begin
        w_load_use = 1'b0;
        w_pending  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (hz.ex_is_load_i && hz.ex_rd_i != '0 &&
                hz.ex_rd_i == hz.id_rs_i[s*REG_AW +: REG_AW])
                w_load_use = 1'b1;
            if (r_busy[hz.id_rs_i[s*REG_AW +: REG_AW]] &&
                !(hz.ld_ret_i && hz.ld_ret_rd_i == hz.id_rs_i[s*REG_AW +: REG_AW]))
                w_pending = 1'b1;
        end
    end

    assign w_waw   = hz.id_is_load_i && r_busy[hz.id_rd_i];
    assign w_cap   = hz.id_is_load_i &&
                     (({1'b0, r_ld_cnt} + CW1'(hz.ld_issue_i)) >= CW1'(MAX_LD));
    assign w_stall = w_load_use || w_pending || w_waw || w_cap;

    // Clear before set so a new load to the same register keeps it busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            if (w_ret_ok)
                r_busy[hz.ld_ret_rd_i] <= 1'b0;
            if (w_set)
                r_busy[hz.ld_issue_rd_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ld_cnt  <= '0;
            r_ret_err <= 1'b0;
        end else begin
            if (hz.ld_issue_i && !w_ret_ok && r_ld_cnt < CW'(MAX_LD))
                r_ld_cnt <= r_ld_cnt + CW'(1);
            else if (w_ret_ok && !hz.ld_issue_i && r_ld_cnt != '0)
                r_ld_cnt <= r_ld_cnt - CW'(1);
            if (hz.ld_ret_i && !r_busy[hz.ld_ret_rd_i])
                r_ret_err <= 1'b1;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign hz.stall_cnt_o = r_stall_cnt;
`else
    assign hz.stall_cnt_o = 32'd0;
`endif

    assign hz.fwd_sel_o = w_fwd_sel;
    assign hz.stall_o   = w_stall;
    assign hz.ld_cnt_o  = r_ld_cnt;
    assign hz.ret_err_o = r_ret_err;
endmodule
